sequenced_demultiplexer: RTL and testbench

SEQUENCED_DEMULTIPLEXER -- requirements
Module: sequenced_demultiplexer

---
 rtl/sequenced_demux_pkg.sv | 19 +
 rtl/five_to_thirty_two_decoder.sv | 18 +
 rtl/sequenced_demultiplexer.sv | 129 ++++++++++++
 tb/tb_sequenced_demultiplexer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sequenced_demux_pkg.sv
// Shared constants and FSM state type for the sequenced demultiplexer.
package sequenced_demux_pkg;

  localparam int LANES = 32;
  localparam int SEL_W = 5;

  // IDLE: pointer at lane 0, nothing written in the current frame.
  // FILL: a partial auto-sequence frame is in progress.
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // True when the index addresses the final lane of a frame.
  function automatic logic is_last_lane(input logic [SEL_W-1:0] idx);
    return idx == SEL_W'(LANES - 1);
  endfunction

endpackage

// File: rtl/five_to_thirty_two_decoder.sv
// One-hot write-enable decoder: a 5-bit lane index becomes a 32-bit
// one-hot vector. All outputs are low when en is low.
module five_to_thirty_two_decoder
  import sequenced_demux_pkg::*;
(
  input  logic [SEL_W-1:0] idx,
  input  logic             en,
  output logic [LANES-1:0] onehot
);

  // Each lane compares the index against its own lane number.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign onehot[gi] = en && (idx == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/sequenced_demultiplexer.sv
// Sequenced 1-to-32 demultiplexer.
// Addressed mode (mode=0) writes ip into lane s. Auto-sequence mode
// (mode=1) writes ip into lane ptr and advances ptr. frame_done pulses
// after lane 31 is written in sequence mode.
// Optional feature: define SEQUENCED_DEMUX_PARITY_EN to add op_parity.
// op_parity holds the XOR of op as captured on each frame_done.
module sequenced_demultiplexer
  import sequenced_demux_pkg::*;
#(
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ip,
  input  logic             ip_valid,
  input  logic [SEL_W-1:0] s,
  input  logic             mode,
  input  logic             clr,
  output logic [LANES-1:0] op,
  output logic [LANES-1:0] op_strobe,
  output logic [SEL_W-1:0] ptr,
  output logic             frame_done
`ifdef SEQUENCED_DEMUX_PARITY_EN
  ,
  output logic             op_parity
`endif
);

  state_t           state_reg, state_next;
  logic [LANES-1:0] op_reg, op_next;
  logic [LANES-1:0] strobe_reg, strobe_next;
  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic             frame_done_reg, frame_done_next;
  logic             mode_reg;

  logic             mode_changed;
  logic [SEL_W-1:0] eff_ptr;
  logic [SEL_W-1:0] wr_idx;
  logic             wr_en;
  logic             seq_write;
  logic [LANES-1:0] wr_onehot;

  // A mode change restarts the sequence at lane 0 at that same edge.
  // This means a write in that cycle already uses the new mode at ptr=0.
  assign mode_changed = (mode != mode_reg);
  assign eff_ptr      = mode_changed ? '0 : ptr_reg;
  assign wr_idx       = mode ? eff_ptr : s;
  assign wr_en        = ip_valid && !clr;
  assign seq_write    = wr_en && mode;

  five_to_thirty_two_decoder u_decoder (
    .idx    (wr_idx),
    .en     (wr_en),
    .onehot (wr_onehot)
  );

  // State register plus all datapath registers. The reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      op_reg         <= RST_VAL;
      strobe_reg     <= '0;
      ptr_reg        <= '0;
      frame_done_reg <= 1'b0;
      mode_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      op_reg         <= op_next;
      strobe_reg     <= strobe_next;
      ptr_reg        <= ptr_next;
      frame_done_reg <= frame_done_next;
      mode_reg       <= mode;
    end
  end

  // Next-state logic: frame begins on a sequence write and ends on lane 31, clr or mode change.
  always_comb begin
    state_next = state_reg;
    if (clr) begin
      state_next = IDLE;
    end else if (seq_write) begin
      state_next = is_last_lane(eff_ptr) ? IDLE : FILL;
    end else if (mode_changed) begin
      state_next = IDLE;
    end
  end

  // Output / datapath logic: merge the written bit into op and form the pulses.
  always_comb begin
    op_next         = op_reg;
    strobe_next     = '0;
    ptr_next        = eff_ptr;
    frame_done_next = 1'b0;
    if (clr) begin
      op_next  = RST_VAL;
      ptr_next = '0;
    end else begin
      op_next     = (op_reg & ~wr_onehot) | (ip ? wr_onehot : '0);
      strobe_next = wr_onehot;
      if (seq_write) begin
        ptr_next        = eff_ptr + 1'b1;
        frame_done_next = is_last_lane(eff_ptr);
      end
    end
  end

  assign op         = op_reg;
  assign op_strobe  = strobe_reg;
  assign ptr        = ptr_reg;
  assign frame_done = frame_done_reg;

`ifdef SEQUENCED_DEMUX_PARITY_EN
  logic parity_reg;

  // Capture the parity of the completed frame alongside frame_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_reg <= 1'b0;
    end else if (clr) begin
      parity_reg <= 1'b0;
    end else if (frame_done_next) begin
      parity_reg <= ^op_next;
    end
  end

  assign op_parity = parity_reg;
`endif

endmodule

// File: tb/tb_sequenced_demultiplexer.sv
// Directed testbench for sequenced_demultiplexer.
// It covers the default build, plus the parity output when
// SEQUENCED_DEMUX_PARITY_EN is defined.
module tb_sequenced_demultiplexer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ip;
  logic        ip_valid;
  logic [4:0]  s;
  logic        mode;
  logic        clr;
  logic [31:0] op;
  logic [31:0] op_strobe;
  logic [4:0]  ptr;
  logic        frame_done;
`ifdef SEQUENCED_DEMUX_PARITY_EN
  logic        op_parity;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int fd_count;

  sequenced_demultiplexer #(.RST_VAL(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .ip         (ip),
    .ip_valid   (ip_valid),
    .s          (s),
    .mode       (mode),
    .clr        (clr),
    .op         (op),
    .op_strobe  (op_strobe),
    .ptr        (ptr),
    .frame_done (frame_done)
`ifdef SEQUENCED_DEMUX_PARITY_EN
    ,
    .op_parity  (op_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ip = 1'b0; ip_valid = 1'b0; s = '0; mode = 1'b0; clr = 1'b0;
    #3;
    check("rst_op", op, 32'h0);
    check("rst_strobe", op_strobe, 32'h0);
    check("rst_ptr", 32'(ptr), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    #9 rst = 1'b0;
    tick();
    $display("[TB] reset released, op=%h ptr=%0d", op, ptr);

    // Addressed write to lane 7
    s = 5'd7; ip = 1'b1; ip_valid = 1'b1;
    tick();
    ip_valid = 1'b0;
    check("addr7_op", op, 32'h0000_0080);
    check("addr7_strobe", op_strobe, 32'h0000_0080);
    check("addr7_ptr", 32'(ptr), 32'h0);
    $display("[TB] addr s=7 ip=1 -> op=%h strobe=%h", op, op_strobe);
    tick();
    check("idle_strobe", op_strobe, 32'h0);
    check("idle_hold_op", op, 32'h0000_0080);
    $display("[TB] idle cycle -> op=%h strobe=%h", op, op_strobe);

    // Addressed lane 31 set, then lane 7 cleared
    s = 5'd31; ip = 1'b1; ip_valid = 1'b1;
    tick();
    check("addr31_op", op, 32'h8000_0080);
    check("addr31_strobe", op_strobe, 32'h8000_0000);
    check("addr31_fd", 32'(frame_done), 32'h0);
    $display("[TB] addr s=31 ip=1 -> op=%h", op);
    s = 5'd7; ip = 1'b0;
    tick();
    ip_valid = 1'b0;
    check("addr7clr_op", op, 32'h8000_0000);
    $display("[TB] addr s=7 ip=0 -> op=%h", op);

    // clr has priority over a write
    clr = 1'b1; ip_valid = 1'b1; s = 5'd3; ip = 1'b1;
    tick();
    clr = 1'b0; ip_valid = 1'b0;
    check("clr_op", op, 32'h0);
    check("clr_strobe", op_strobe, 32'h0);
    check("clr_ptr", 32'(ptr), 32'h0);
    $display("[TB] clr+write -> op=%h strobe=%h ptr=%0d", op, op_strobe, ptr);

    // Full sequence frame of ones
    mode = 1'b1; ip = 1'b1; ip_valid = 1'b1; fd_count = 0;
    tick();
    if (frame_done) fd_count++;
    check("seq1_op", op, 32'h0000_0001);
    check("seq1_strobe", op_strobe, 32'h0000_0001);
    check("seq1_ptr", 32'(ptr), 32'd1);
    $display("[TB] seq write 1 -> op=%h ptr=%0d", op, ptr);
    for (int i = 1; i < 31; i++) begin
      tick();
      if (frame_done) fd_count++;
    end
    check("seq31_ptr", 32'(ptr), 32'd31);
    check("seq31_op", op, 32'h7FFF_FFFF);
    $display("[TB] seq write 31 -> op=%h ptr=%0d", op, ptr);
    tick();
    ip_valid = 1'b0;
    if (frame_done) fd_count++;
    check("seq32_op", op, 32'hFFFF_FFFF);
    check("seq32_ptr", 32'(ptr), 32'h0);
    check("seq32_fd", 32'(frame_done), 32'h1);
    check("seq32_strobe", op_strobe, 32'h8000_0000);
    $display("[TB] seq write 32 -> op=%h ptr=%0d fd=%0d", op, ptr, frame_done);
    tick();
    if (frame_done) fd_count++;
    check("fd_count", 32'(fd_count), 32'd1);
    check("hold_ptr", 32'(ptr), 32'h0);
    check("hold_op", op, 32'hFFFF_FFFF);
    $display("[TB] idle after frame -> fd_count=%0d", fd_count);

    // Five sequence writes of zero, then switch to addressed mode
    ip = 1'b0; ip_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    ip_valid = 1'b0;
    check("seq5_ptr", 32'(ptr), 32'd5);
    check("seq5_op", op, 32'hFFFF_FFE0);
    $display("[TB] 5 seq writes -> op=%h ptr=%0d", op, ptr);
    mode = 1'b0;
    tick();
    check("modechg_ptr", 32'(ptr), 32'h0);
    $display("[TB] mode->0 -> ptr=%0d", ptr);
    s = 5'd2; ip = 1'b1; ip_valid = 1'b1;
    tick();
    ip_valid = 1'b0;
    check("addr2_op", op, 32'hFFFF_FFE4);
    check("addr2_ptr", 32'(ptr), 32'h0);
    $display("[TB] addr s=2 -> op=%h ptr=%0d", op, ptr);

    // Mode back to sequence with a write in that same cycle: lane 0
    mode = 1'b1; ip = 1'b1; ip_valid = 1'b1;
    tick();
    check("modewr_op", op, 32'hFFFF_FFE5);
    check("modewr_ptr", 32'(ptr), 32'd1);
    check("modewr_strobe", op_strobe, 32'h0000_0001);
    $display("[TB] mode->1 with write -> op=%h ptr=%0d", op, ptr);

    // Reach ptr=12, then reset asynchronously between edges
    for (int i = 0; i < 11; i++) tick();
    ip_valid = 1'b0;
    check("pre_rst_ptr", 32'(ptr), 32'd12);
    #2 rst = 1'b1;
    #1;
    check("async_op", op, 32'h0);
    check("async_ptr", 32'(ptr), 32'h0);
    $display("[TB] async rst mid-frame -> op=%h ptr=%0d", op, ptr);
    #1 rst = 1'b0;
    ip = 1'b1; ip_valid = 1'b1;
    tick();
    ip_valid = 1'b0;
    check("postrst_op", op, 32'h0000_0001);
    check("postrst_ptr", 32'(ptr), 32'd1);
    $display("[TB] first post-reset seq write -> op=%h ptr=%0d", op, ptr);

`ifdef SEQUENCED_DEMUX_PARITY_EN
    // Frame of three ones and 29 zeros gives odd parity
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("par_clr", 32'(op_parity), 32'h0);
    ip_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ip = (i < 3);
      tick();
    end
    ip_valid = 1'b0;
    check("par_fd", 32'(frame_done), 32'h1);
    check("par_val", 32'(op_parity), 32'h1);
    $display("[TB] parity frame -> op=%h parity=%0d", op, op_parity);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
